// File: rtl/alu_collect_pkg.sv
// Shared types and helpers for the ALU operand collector.
// The command encoding matches the ALU. Optional feature macro:
// ALU_COLLECT_CMD_CHECK_EN.
`ifndef DWIDTH
`define DWIDTH 8
`endif
`ifndef CWIDTH
`define CWIDTH 4
`endif

package alu_collect_pkg;

  localparam int DWIDTH_DEF   = `DWIDTH;
  localparam int CWIDTH_DEF   = `CWIDTH;
  localparam int TIMEOUT_DEF  = 16;
  localparam int MUL_HOLD_DEF = 3;

  // Arithmetic commands (mode = 1).
  typedef enum logic [3:0] {
    CMD_ADD     = 4'd0,
    CMD_SUB     = 4'd1,
    CMD_ADD_CIN = 4'd2,
    CMD_SUB_CIN = 4'd3,
    CMD_INC_A   = 4'd4,
    CMD_DEC_A   = 4'd5,
    CMD_INC_B   = 4'd6,
    CMD_DEC_B   = 4'd7,
    CMD_CMP     = 4'd8,
    CMD_ADD_MUL = 4'd9,
    CMD_SH_MUL  = 4'd10
  } arith_cmd_e;

  // Logical commands (mode = 0).
  typedef enum logic [3:0] {
    CMD_AND     = 4'd0,
    CMD_NAND    = 4'd1,
    CMD_OR      = 4'd2,
    CMD_NOR     = 4'd3,
    CMD_XOR     = 4'd4,
    CMD_XNOR    = 4'd5,
    CMD_NOT_A   = 4'd6,
    CMD_NOT_B   = 4'd7,
    CMD_SHR1_A  = 4'd8,
    CMD_SHL1_A  = 4'd9,
    CMD_SHR1_B  = 4'd10,
    CMD_SHL1_B  = 4'd11,
    CMD_ROL_A_B = 4'd12,
    CMD_ROR_A_B = 4'd13
  } logic_cmd_e;

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, HOLD} state_e;

  // Timer operations requested by the collector FSM.
  typedef enum logic [2:0] {TMR_CLR, TMR_START, TMR_INC, TMR_LOAD, TMR_DEC} timer_op_e;

  // True when the command consumes both operands.
  function automatic logic need_both(input logic mode, input logic [3:0] cmd);
    logic both;
    both = 1'b0;
    if (mode) begin
      case (cmd)
        CMD_ADD, CMD_SUB, CMD_ADD_CIN, CMD_SUB_CIN,
        CMD_CMP, CMD_SH_MUL, CMD_ADD_MUL: both = 1'b1;
        default:                          both = 1'b0;
      endcase
    end else begin
      case (cmd)
        CMD_AND, CMD_NAND, CMD_OR, CMD_NOR,
        CMD_XOR, CMD_XNOR, CMD_ROL_A_B, CMD_ROR_A_B: both = 1'b1;
        default:                                   both = 1'b0;
      endcase
    end
    return both;
  endfunction

  // Multiply commands need their inputs held for the ALU's extra cycles.
  function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
    return mode && ((cmd == CMD_SH_MUL) || (cmd == CMD_ADD_MUL));
  endfunction

endpackage

// File: rtl/alu_operand_collector_if.sv
// Upstream beat bus plus ALU pin bundle of the operand collector.
// err_cmd exists only when ALU_COLLECT_CMD_CHECK_EN is defined.
interface alu_operand_collector_if #(
  parameter int DWIDTH = alu_collect_pkg::DWIDTH_DEF,
  parameter int CWIDTH = alu_collect_pkg::CWIDTH_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_inp_valid;
  logic [DWIDTH-1:0] in_opa;
  logic [DWIDTH-1:0] in_opb;
  logic              in_mode;
  logic [CWIDTH-1:0] in_cmd;
  logic              in_cin;
  logic              alu_ce;
  logic [DWIDTH-1:0] alu_opa;
  logic [DWIDTH-1:0] alu_opb;
  logic              alu_mode;
  logic [CWIDTH-1:0] alu_cmd;
  logic              alu_cin;
  logic [1:0]        alu_inp_valid;
  logic              err_timeout;
  logic              busy;
`ifdef ALU_COLLECT_CMD_CHECK_EN
  logic              err_cmd;
`endif

  // Collector side.
  modport slave (
    input  in_valid, in_inp_valid, in_opa, in_opb, in_mode, in_cmd, in_cin,
    output in_ready, alu_ce, alu_opa, alu_opb, alu_mode, alu_cmd, alu_cin,
           alu_inp_valid, err_timeout, busy
`ifdef ALU_COLLECT_CMD_CHECK_EN
    , output err_cmd
`endif
  );

  // Beat source / observer side.
  modport master (
    output in_valid, in_inp_valid, in_opa, in_opb, in_mode, in_cmd, in_cin,
    input  in_ready, alu_ce, alu_opa, alu_opb, alu_mode, alu_cmd, alu_cin,
           alu_inp_valid, err_timeout, busy
`ifdef ALU_COLLECT_CMD_CHECK_EN
    , input err_cmd
`endif
  );
endinterface

// File: rtl/alu_collect_timer.sv
// Collection-window up-counter that doubles as the multiply-hold down-counter.
// MUL_HOLD must not exceed TIMEOUT so both fit in CW bits.
module alu_collect_timer
  import alu_collect_pkg::*;
#(
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int MUL_HOLD = MUL_HOLD_DEF,
  parameter int CW       = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  timer_op_e     op,
  output logic [CW-1:0] cnt,
  output logic          expired,
  output logic          hold_last
);

  // Counter register: START loads 1 because the first beat's own cycle counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      cnt <= '0;
    end else begin
      case (op)
        TMR_START: cnt <= CW'(1);
        TMR_INC:   cnt <= cnt + CW'(1);
        TMR_LOAD:  cnt <= CW'(MUL_HOLD);
        TMR_DEC:   cnt <= cnt - CW'(1);
        default:   cnt <= '0;
      endcase
    end
  end

  assign expired   = (cnt == CW'(TIMEOUT));
  assign hold_last = (cnt == CW'(1));

endmodule

// File: rtl/alu_operand_collector.sv
// Merges A/B operand beats into one stable command set for the ALU, enforces
// the arrival window and holds multiply commands. Optional feature macro:
// ALU_COLLECT_CMD_CHECK_EN (adds err_cmd and restarts on mode/cmd mismatch).
module alu_operand_collector
  import alu_collect_pkg::*;
#(
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int CWIDTH   = CWIDTH_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int MUL_HOLD = MUL_HOLD_DEF
) (
  input logic                    clk,
  input logic                    rst,
  alu_operand_collector_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e            state, state_nxt;
  logic [DWIDTH-1:0] hold_opa, hold_opb, opa_nxt, opb_nxt;
  logic              hold_mode, mode_nxt, hold_cin, cin_nxt;
  logic [CWIDTH-1:0] hold_cmd, cmd_nxt;
  logic [1:0]        flags, flags_nxt;
  logic              flags_clr, complete, accept, ready, restart, timeout_nxt;
  timer_op_e         tmr_op;
  logic [CW-1:0]     cnt;
  logic              expired, hold_last;

  logic              ce_q, mode_q, cin_q, timeout_q;
  logic [1:0]        inp_valid_q;
  logic [DWIDTH-1:0] opa_q, opb_q;
  logic [CWIDTH-1:0] cmd_q;

  alu_collect_timer #(.TIMEOUT(TIMEOUT), .MUL_HOLD(MUL_HOLD), .CW(CW)) u_timer (
    .clk(clk), .rst(rst), .op(tmr_op), .cnt(cnt), .expired(expired), .hold_last(hold_last)
  );

  assign ready  = (state == IDLE) || (state == COLLECT);
  assign accept = bus.in_valid && ready && (bus.in_inp_valid != 2'b00);

  // Next-state, operand merge and timer control.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned and no latch is inferred.
    state_nxt   = state;
    mode_nxt    = hold_mode;
    cmd_nxt     = hold_cmd;
    cin_nxt     = hold_cin;
    opa_nxt     = hold_opa;
    opb_nxt     = hold_opb;
    flags_nxt   = flags;
    flags_clr   = 1'b0;
    tmr_op      = TMR_CLR;
    timeout_nxt = 1'b0;
    restart     = 1'b0;
`ifdef ALU_COLLECT_CMD_CHECK_EN
    restart = (state == COLLECT) && accept &&
              ((bus.in_mode != hold_mode) || (bus.in_cmd != hold_cmd));
`endif
    if (accept) begin
      if ((state == IDLE) || restart) begin
        mode_nxt  = bus.in_mode;
        cmd_nxt   = bus.in_cmd;
        cin_nxt   = bus.in_cin;
        flags_nxt = bus.in_inp_valid;
      end else begin
        flags_nxt = flags | bus.in_inp_valid;
      end
      if (bus.in_inp_valid[0]) opa_nxt = bus.in_opa;
      if (bus.in_inp_valid[1]) opb_nxt = bus.in_opb;
    end
    complete = need_both(mode_nxt, cmd_nxt[3:0]) ? (flags_nxt == 2'b11)
                                                 : (flags_nxt != 2'b00);
    case (state)
      IDLE: begin
        if (accept) begin
          if (complete) begin
            state_nxt = ISSUE;
          end else begin
            state_nxt = COLLECT;
            tmr_op    = TMR_START;
          end
        end
      end
      COLLECT: begin
        if (complete) begin
          state_nxt = ISSUE;
        end else if (restart) begin
          tmr_op = TMR_START;
        end else if (expired) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
          flags_clr   = 1'b1;
        end else begin
          tmr_op = TMR_INC;
        end
      end
      ISSUE: begin
        flags_clr = 1'b1;
        if (is_mul(hold_mode, hold_cmd[3:0])) begin
          state_nxt = HOLD;
          tmr_op    = TMR_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (hold_last) state_nxt = IDLE;
        else           tmr_op    = TMR_DEC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and the partially collected operand set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hold_opa  <= '0;
      hold_opb  <= '0;
      hold_mode <= 1'b0;
      hold_cmd  <= '0;
      hold_cin  <= 1'b0;
      flags     <= '0;
    end else begin
      state     <= state_nxt;
      hold_opa  <= opa_nxt;
      hold_opb  <= opb_nxt;
      hold_mode <= mode_nxt;
      hold_cmd  <= cmd_nxt;
      hold_cin  <= cin_nxt;
      flags     <= flags_clr ? 2'b00 : flags_nxt;
    end
  end

  // Registered ALU pins: payload loads on entry to ISSUE and holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_q        <= 1'b0;
      inp_valid_q <= 2'b00;
      opa_q       <= '0;
      opb_q       <= '0;
      mode_q      <= 1'b0;
      cmd_q       <= '0;
      cin_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      ce_q        <= (state_nxt == ISSUE) || (state_nxt == HOLD);
      inp_valid_q <= ((state_nxt == ISSUE) || (state_nxt == HOLD)) ? 2'b11 : 2'b00;
      timeout_q   <= timeout_nxt;
      if (state_nxt == ISSUE) begin
        opa_q  <= opa_nxt;
        opb_q  <= opb_nxt;
        mode_q <= mode_nxt;
        cmd_q  <= cmd_nxt;
        cin_q  <= cin_nxt;
      end
    end
  end

`ifdef ALU_COLLECT_CMD_CHECK_EN
  logic cmd_err_q;

  // One-cycle pulse for a beat that disagreed with the latched mode/cmd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cmd_err_q <= 1'b0;
    else      cmd_err_q <= restart;
  end

  assign bus.err_cmd = cmd_err_q;
`endif

  assign bus.in_ready      = ready;
  assign bus.busy          = (state != IDLE);
  assign bus.alu_ce        = ce_q;
  assign bus.alu_inp_valid = inp_valid_q;
  assign bus.alu_opa       = opa_q;
  assign bus.alu_opb       = opb_q;
  assign bus.alu_mode      = mode_q;
  assign bus.alu_cmd       = cmd_q;
  assign bus.alu_cin       = cin_q;
  assign bus.err_timeout   = timeout_q;

endmodule

// File: tb/tb_alu_operand_collector.sv
// Self-checking bench for alu_operand_collector: directed scenarios followed by
// random beats, all compared every cycle against a timestamp-based model.
module tb_alu_operand_collector;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int TO = 16;
  localparam int MH = 3;

  localparam logic [3:0] C_ADD = 4'd0, C_SUB = 4'd1, C_XOR = 4'd4,
                         C_CMP = 4'd8, C_ADD_MUL = 4'd9, C_SH_MUL = 4'd10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_operand_collector_if #(.DWIDTH(DW), .CWIDTH(CW)) bus ();

  alu_operand_collector #(.DWIDTH(DW), .CWIDTH(CW), .TIMEOUT(TO), .MUL_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int passed = 0;
  int cyc = 0;

  // Model: the pending set plus timestamps of the events it predicts.
  bit          m_coll;
  int          m_first;
  logic [1:0]  m_flags;
  logic [7:0]  m_a, m_b, e_opa, e_opb;
  logic        m_mode, m_cin, e_mode, e_cin;
  logic [3:0]  m_cmd, e_cmd;
  int          issue_at, issue_end, tmo_at, cerr_at;

  function automatic bit model_need_both(logic mode, logic [3:0] cmd);
    if (mode) return cmd inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10};
    return cmd inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd12, 4'd13};
  endfunction

  function automatic bit in_issue(int c);
    return (c >= issue_at) && (c <= issue_end);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic check_outputs();
    bit act;
    act = in_issue(cyc);
    check("alu_ce", bus.alu_ce, act);
    check("alu_inp_valid", bus.alu_inp_valid, act ? 2'b11 : 2'b00);
    check("alu_opa", bus.alu_opa, e_opa);
    check("alu_opb", bus.alu_opb, e_opb);
    check("alu_mode", bus.alu_mode, e_mode);
    check("alu_cmd", bus.alu_cmd, e_cmd);
    check("alu_cin", bus.alu_cin, e_cin);
    check("err_timeout", bus.err_timeout, cyc == tmo_at);
    check("in_ready", bus.in_ready, !act);
    check("busy", bus.busy, m_coll || act);
`ifdef ALU_COLLECT_CMD_CHECK_EN
    check("err_cmd", bus.err_cmd, cyc == cerr_at);
`endif
  endtask

  task automatic model_reset();
    m_coll = 0; m_first = 0; m_flags = 0;
    m_a = 0; m_b = 0; m_mode = 0; m_cin = 0; m_cmd = 0;
    e_opa = 0; e_opb = 0; e_mode = 0; e_cin = 0; e_cmd = 0;
    issue_at = -1000; issue_end = -1000; tmo_at = -1; cerr_at = -1;
  endtask

  // Applies the beat presented during cycle cyc to the model.
  task automatic model_step(input logic v, input logic [1:0] bits, input logic mode,
                            input logic [3:0] cmd, input logic cin,
                            input logic [7:0] a, input logic [7:0] b);
    bit acc, restart, done;
    acc = v && !in_issue(cyc) && (bits != 2'b00);
    restart = 0;
    if (acc) begin
`ifdef ALU_COLLECT_CMD_CHECK_EN
      if (m_coll && ((mode != m_mode) || (cmd != m_cmd))) begin
        restart = 1;
        cerr_at = cyc + 1;
      end
`endif
      if (!m_coll || restart) begin
        m_first = cyc; m_mode = mode; m_cmd = cmd; m_cin = cin; m_flags = bits;
      end else begin
        m_flags = m_flags | bits;
      end
      if (bits[0]) m_a = a;
      if (bits[1]) m_b = b;
      m_coll = 1;
      done = model_need_both(m_mode, m_cmd) ? (m_flags == 2'b11) : (m_flags != 2'b00);
      if (done) begin
        issue_at  = cyc + 1;
        issue_end = cyc + 1 + ((m_mode && (m_cmd == C_SH_MUL || m_cmd == C_ADD_MUL)) ? MH : 0);
        e_opa = m_a; e_opb = m_b; e_mode = m_mode; e_cmd = m_cmd; e_cin = m_cin;
        m_coll = 0; m_flags = 0;
      end
    end
    if (m_coll && (cyc - m_first >= TO)) begin
      tmo_at = cyc + 1;
      m_coll = 0;
      m_flags = 0;
    end
  endtask

  task automatic beat(input logic v, input logic [1:0] bits, input logic mode,
                      input logic [3:0] cmd, input logic cin,
                      input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = v; bus.in_inp_valid = bits; bus.in_mode = mode;
    bus.in_cmd = cmd; bus.in_cin = cin; bus.in_opa = a; bus.in_opb = b;
    model_step(v, bits, mode, cmd, cin, a, b);
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00);
  endtask

  // Asynchronous reset mid-cycle; outputs are checked before any clock edge.
  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_inp_valid = 2'b00;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  initial begin
    logic [7:0] ra, rb;
    bus.in_valid = 1'b0; bus.in_inp_valid = 2'b00; bus.in_opa = '0; bus.in_opb = '0;
    bus.in_mode = 1'b0; bus.in_cmd = '0; bus.in_cin = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Single full beat.
    beat(1'b1, 2'b11, 1'b1, C_ADD, 1'b0, 8'h12, 8'h34);
    idle(2);

    // Split beats at the window edge: B arrives at cycle 16.
    beat(1'b1, 2'b01, 1'b0, C_XOR, 1'b1, 8'hF0, 8'h00);
    idle(15);
    beat(1'b1, 2'b10, 1'b0, C_XOR, 1'b0, 8'h00, 8'h0F);
    idle(2);

    // Timeout, then a fresh B-only collection at cycle 18 completed by A.
    beat(1'b1, 2'b01, 1'b1, C_SUB, 1'b0, 8'h5A, 8'h00);
    idle(17);
    beat(1'b1, 2'b10, 1'b1, C_SUB, 1'b0, 8'h00, 8'hA5);
    idle(3);
    beat(1'b1, 2'b01, 1'b1, C_SUB, 1'b0, 8'h3C, 8'h00);
    idle(2);

    // Multiply hold with a beat offered during HOLD.
    ra = 8'($urandom); rb = 8'($urandom);
    beat(1'b1, 2'b11, 1'b1, C_SH_MUL, 1'b1, ra, rb);
    idle(1);
    beat(1'b1, 2'b11, 1'b0, C_AND_OR_DUMMY(), 1'b0, 8'hFF, 8'hFF);
    idle(4);

    // Reset mid-collection, then a B-only need_both beat waits.
    beat(1'b1, 2'b01, 1'b1, C_ADD, 1'b0, 8'h77, 8'h00);
    idle(2);
    do_reset();
    beat(1'b1, 2'b10, 1'b1, C_CMP, 1'b0, 8'h00, 8'h99);
    idle(18);

    // Reset mid-HOLD aborts the held multiply.
    beat(1'b1, 2'b11, 1'b1, C_ADD_MUL, 1'b0, 8'h21, 8'h43);
    idle(2);
    do_reset();
    idle(1);

    // Command mismatch mid-collection.
    beat(1'b1, 2'b01, 1'b1, C_ADD, 1'b0, 8'h11, 8'h00);
    idle(1);
    beat(1'b1, 2'b10, 1'b1, C_CMP, 1'b0, 8'h00, 8'h22);
    idle(18);

    // Random beats: busy phase, then a sparse phase that provokes timeouts.
    for (int i = 0; i < 300; i++)
      beat(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom),
           4'($urandom_range(0, 15)), 1'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 150; i++)
      beat(1'($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)), 1'($urandom),
           4'($urandom_range(0, 15)), 1'($urandom), 8'($urandom), 8'($urandom));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Logical AND command used for the beat offered while the collector is busy.
  function automatic logic [3:0] C_AND_OR_DUMMY();
    return 4'd0;
  endfunction

endmodule
